// File: rtl/ex_pkg.sv
// Shared opcode encodings and FSM state constants for the SimpleRISC execute stage.
package ex_pkg;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_OR   = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_LSL  = 5'b01010;
    localparam logic [4:0] OP_LSR  = 5'b01011;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_STOP = 5'b11111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/ex_unit_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, DIV_CYCLES iterations.
module serial_divider #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(DIV_CYCLES);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] dsr;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
    assign trial = {remainder, quotient[XLEN-1]};
    assign diff  = trial - {1'b0, dsr};
    // done marks the cycle whose closing edge performs the final iteration
    assign done  = busy && (cnt == CW'(DIV_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (busy) begin
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= trial[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_unit.sv
// SimpleRISC execute stage: single-cycle ALU, E/GT flags, branch resolution,
// and a stalling signed div/mod built on the serial divider.
module ex_unit
    import ex_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcodeI,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] branchTarget,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] aluResult,
    output logic [XLEN-1:0] storeData,
    output logic [4:0]      rd_out,
    output logic [4:0]      opcode_out,
    output logic            isBranchTaken,
    output logic [XLEN-1:0] branchPC,
    output logic            flagE,
    output logic            flagGT,
    output logic            halted
);
    logic [1:0]      state;
    logic [4:0]      op;
    logic            accept, is_divop, div_go, taken;
    logic            qneg, rneg, is_mod;
    logic [XLEN-1:0] alu_res, bpc, abs_a, abs_b, q_fin, r_fin, div_res;
    logic            div_done;
    logic [XLEN-1:0] div_q, div_r;
    logic            unused_i;

    // the immediate flag is already folded into B by operand fetch
    assign op       = opcodeI[5:1];
    assign unused_i = opcodeI[0];

    assign in_ready = (state == IDLE) && !halted;
    assign accept   = in_valid && in_ready && !flush;
    assign is_divop = (op == OP_DIV) || (op == OP_MOD);
    assign div_go   = accept && is_divop && (B != '0);

    assign abs_a = A[XLEN-1] ? -A : A;
    assign abs_b = B[XLEN-1] ? -B : B;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD, OP_LD, OP_ST: alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_MUL:  alu_res = A * B;
            OP_DIV:  alu_res = '1;   // divide-by-zero bypass; non-zero divisors go serial
            OP_MOD:  alu_res = A;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOT:  alu_res = ~B;
            OP_MOV:  alu_res = B;
            OP_LSL:  alu_res = A << B[4:0];
            OP_LSR:  alu_res = A >> B[4:0];
            OP_ASR:  alu_res = $signed(A) >>> B[4:0];
            OP_CALL: alu_res = pc + XLEN'(4);
            default: alu_res = '0;
        endcase
    end

    assign taken = (op == OP_B) || (op == OP_CALL) || (op == OP_RET) ||
                   ((op == OP_BEQ) && flagE) || ((op == OP_BGT) && flagGT);
    assign bpc   = !taken ? '0 : ((op == OP_RET) ? A : branchTarget);

    assign q_fin   = qneg ? -div_q : div_q;
    assign r_fin   = rneg ? -div_r : div_r;
    assign div_res = is_mod ? r_fin : q_fin;

    serial_divider #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_go),
        .abort     (flush && (state != IDLE)),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            aluResult     <= '0;
            storeData     <= '0;
            rd_out        <= '0;
            opcode_out    <= '0;
            isBranchTaken <= 1'b0;
            branchPC      <= '0;
            flagE         <= 1'b0;
            flagGT        <= 1'b0;
            halted        <= 1'b0;
            qneg          <= 1'b0;
            rneg          <= 1'b0;
            is_mod        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    storeData     <= op2;
                    rd_out        <= rd;
                    opcode_out    <= op;
                    isBranchTaken <= taken;
                    branchPC      <= bpc;
                    if (div_go) begin
                        state  <= DIV;
                        qneg   <= A[XLEN-1] ^ B[XLEN-1];
                        rneg   <= A[XLEN-1];
                        is_mod <= (op == OP_MOD);
                    end else begin
                        aluResult <= alu_res;
                        out_valid <= 1'b1;
                    end
                    if (op == OP_CMP) begin
                        flagE  <= (A == B);
                        flagGT <= ($signed(A) > $signed(B));
                    end
                    if (op == OP_STOP) halted <= 1'b1;
                end
                DIV: begin
                    if (flush)         state <= IDLE;
                    else if (div_done) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    // a flush landing on the final cycle still kills the result
                    if (!flush) begin
                        aluResult <= div_res;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_unit.sv
// Scoreboard bench for ex_unit: directed vectors push expectations, a monitor pops on out_valid.
module tb_ex_unit;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  opcodeI = '0;
    logic [31:0] A = '0, B = '0, op2 = '0, pc = '0, branchTarget = '0;
    logic [4:0]  rd = '0;
    logic        in_ready, out_valid, isBranchTaken, flagE, flagGT, halted;
    logic [31:0] aluResult, storeData, branchPC;
    logic [4:0]  rd_out, opcode_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued = 0;

    typedef struct {
        string       name;
        logic [31:0] alu;
        bit          chk;
        bit          tk;
        logic [31:0] bpc;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [4:0]  op;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    ex_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcodeI(opcodeI), .A(A), .B(B), .op2(op2), .rd(rd), .pc(pc),
        .branchTarget(branchTarget), .flush(flush), .out_valid(out_valid),
        .aluResult(aluResult), .storeData(storeData), .rd_out(rd_out),
        .opcode_out(opcode_out), .isBranchTaken(isBranchTaken), .branchPC(branchPC),
        .flagE(flagE), .flagGT(flagGT), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] tgt,
                         input bit expv, input logic [31:0] ealu, input bit chk,
                         input bit etk, input logic [31:0] ebpc, input int lat);
        int n = 0;
        exp_t e;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s issue: in_ready stuck at 0, required 1", name);
        end
        issued++;
        opcodeI = {op, 1'b0};
        A = a; B = b; pc = p; branchTarget = tgt;
        op2 = 32'hC0DE0000 | 32'(issued);
        rd = 5'(issued);
        in_valid = 1'b1;
        if (expv) begin
            e.name = name; e.alu = ealu; e.chk = chk; e.tk = etk; e.bpc = ebpc;
            e.sd = op2; e.rd = rd; e.op = op; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected out_valid: aluResult %h, required no retirement", aluResult);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) check({e.name, " aluResult"}, aluResult, e.alu);
                    check({e.name, " taken"}, 32'(isBranchTaken), 32'(e.tk));
                    check({e.name, " branchPC"}, branchPC, e.bpc);
                    check({e.name, " storeData"}, storeData, e.sd);
                    check({e.name, " rd_out"}, 32'(rd_out), 32'(e.rd));
                    check({e.name, " opcode_out"}, 32'(opcode_out), 32'(e.op));
                    check({e.name, " latency cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        repeat (3) @(negedge clk);
        check("reset aluResult", aluResult, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset flags", {30'h0, flagE, flagGT}, 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        check("reset branch", {31'h0, isBranchTaken} | branchPC, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'h1);

        // single-cycle ALU
        issue("add wrap", OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 0, 1, 32'h80000000, 1, 0, 0, 1);
        issue("sub",      OP_SUB, 32'd3, 32'd5, 0, 0, 1, 32'hFFFFFFFE, 1, 0, 0, 1);
        issue("mul",      OP_MUL, 32'h10000, 32'h10000, 0, 0, 1, 32'h0, 1, 0, 0, 1);
        issue("asr",      OP_ASR, 32'h80000000, 32'd4, 0, 0, 1, 32'hF8000000, 1, 0, 0, 1);
        issue("lsl",      OP_LSL, 32'h1, 32'd31, 0, 0, 1, 32'h80000000, 1, 0, 0, 1);
        issue("lsr",      OP_LSR, 32'h80000000, 32'h3F, 0, 0, 1, 32'h1, 1, 0, 0, 1);
        issue("not",      OP_NOT, 32'h12345678, 32'h0, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 1);
        issue("ld",       OP_LD, 32'h100, 32'h20, 0, 0, 1, 32'h120, 1, 0, 0, 1);

        // flags and branches
        issue("cmp eq", OP_CMP, 32'd5, 32'd5, 0, 0, 1, 0, 0, 0, 0, 1);
        check("cmp eq flagE", 32'(flagE), 32'h1);
        issue("beq", OP_BEQ, 0, 0, 32'h10, 32'h40, 1, 0, 0, 1, 32'h40, 1);
        issue("cmp lt", OP_CMP, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 0, 0, 0, 0, 1);
        check("cmp lt flags", {30'h0, flagE, flagGT}, 32'h0);
        issue("bgt not", OP_BGT, 0, 0, 32'h14, 32'h80, 1, 0, 0, 0, 32'h0, 1);
        issue("cmp gt", OP_CMP, 32'd7, 32'hFFFFFFFD, 0, 0, 1, 0, 0, 0, 0, 1);
        issue("bgt take", OP_BGT, 0, 0, 32'h18, 32'h90, 1, 0, 0, 1, 32'h90, 1);
        issue("ret", OP_RET, 32'h100, 0, 32'h1C, 32'h44, 1, 0, 0, 1, 32'h100, 1);
        issue("call", OP_CALL, 0, 0, 32'h20, 32'h80, 1, 32'h24, 1, 1, 32'h80, 1);
        issue("b", OP_B, 0, 0, 32'h24, 32'h60, 1, 0, 0, 1, 32'h60, 1);

        // division
        issue("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 32'hFFFFFFFD, 1, 0, 0, 34);
        lo = 0;
        while (!in_ready && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("div in_ready low cycles", 32'(lo), 32'd33);
        issue("mod -7%2", OP_MOD, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 34);
        issue("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 32'h80000000, 1, 0, 0, 34);
        issue("mod min/-1", OP_MOD, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 1, 0, 0, 34);
        issue("div by 0", OP_DIV, 32'd9, 32'd0, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 1);
        issue("mod by 0", OP_MOD, 32'd9, 32'd0, 0, 0, 1, 32'd9, 1, 0, 0, 1);
        issue("div 100/7", OP_DIV, 32'd100, 32'd7, 0, 0, 1, 32'd14, 1, 0, 0, 34);
        issue("mod 100/-7", OP_MOD, 32'd100, 32'hFFFFFFF9, 0, 0, 1, 32'd2, 1, 0, 0, 34);
        issue("div -100/7", OP_DIV, 32'hFFFFFF9C, 32'd7, 0, 0, 1, 32'hFFFFFFF2, 1, 0, 0, 34);

        // flush in IDLE suppresses the accept
        while (!in_ready) @(negedge clk);
        opcodeI = {OP_ADD, 1'b0}; A = 32'd1; B = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle flush out_valid", 32'(out_valid), 32'h0);

        // flush at cycle 10 of a divide
        issue("div flushed", OP_DIV, 32'd1000, 32'd3, 0, 0, 0, 0, 0, 0, 0, 34);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready cycle 11", 32'(in_ready), 32'h1);
        check("flush out_valid", 32'(out_valid), 32'h0);
        repeat (40) @(negedge clk);
        issue("add after flush", OP_ADD, 32'd2, 32'd3, 0, 0, 1, 32'd5, 1, 0, 0, 1);

        // async reset mid-division
        issue("cmp pre-reset", OP_CMP, 32'd5, 32'd5, 0, 0, 1, 0, 0, 0, 0, 1);
        issue("div reset", OP_DIV, 32'd50, 32'd5, 0, 0, 0, 0, 0, 0, 0, 34);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst aluResult", aluResult, 32'h0);
        check("rst flags/valid", {28'h0, flagE, flagGT, out_valid, halted}, 32'h0);
        check("rst rd/opcode", {22'h0, rd_out, opcode_out}, 32'h0);
        check("rst storeData", storeData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after mid-div reset", 32'(in_ready), 32'h1);
        repeat (40) @(negedge clk);

        // stop, then halted holds off further work
        issue("stop", OP_STOP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        check("halted", 32'(halted), 32'h1);
        opcodeI = {OP_ADD, 1'b0}; A = 32'd1; B = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("in_ready while halted", 32'(in_ready), 32'h0);
            @(negedge clk);
        end
        in_valid = 1'b0;

        lo = 0;
        while (sb.size() != 0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Execute stage of the SimpleRISC pipeline, directly downstream of operand fetch.
- Consumes the OF outputs A, B, op2, opcodeI, rd, pc and branchTarget, and computes the ALU result.
- Holds the architectural E/GT flags and resolves branches.
- mul is single-cycle; div/mod run on a 32-iteration serial divider, during which the unit stalls upstream through in_ready.

Parameters:
- XLEN, 32, datapath width.
- DIV_CYCLES, 32, divider iteration count; must equal XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  OF presents a valid instruction.
- in_ready  out  1  unit accepts this cycle; equals (state==IDLE && !halted).
- opcodeI  in  6  {opcode[4:0], I}.
- A  in  XLEN  first operand.
- B  in  XLEN  second operand (immx already selected when I=1).
- op2  in  XLEN  store data.
- rd  in  5  destination register.
- pc  in  XLEN  instruction PC.
- branchTarget  in  XLEN  pc-relative target.
- flush  in  1  kill the in-flight instruction.
- out_valid  out  1  one-cycle pulse per retired instruction.
- aluResult  out  XLEN  result / effective address.
- storeData  out  XLEN  registered op2.
- rd_out  out  5  registered rd.
- opcode_out  out  5  registered opcode.
- isBranchTaken  out  1  valid with out_valid.
- branchPC  out  XLEN  redirect target.
- flagE, flagGT  out  1  current flags.
- halted  out  1  sticky; set after opcode 11111 retires.

Behaviour:
- Reset (async, rst_n=0): all outputs and registers 0, state=IDLE, in_ready=1 once rst_n deasserts.
- Accept condition: in_valid && in_ready at a rising edge.
- Opcodes: add 00000, sub 00001, mul 00010, div 00011, mod 00100, cmp 00101, and 00110, or 00111, not 01000, mov 01001, lsl 01010, lsr 01011, asr 01100, nop 01101, ld 01110, st 01111, beq 10000, bgt 10001, b 10010, call 10011, ret 10100, stop 11111.
- Single-cycle ops: outputs registered at the accept edge; out_valid high for exactly that next cycle. Latency 1.
- Arithmetic: add/sub/mul use low XLEN bits, wrap modulo 2^32. not = ~B; mov = B.
- Shifts: amount = B[4:0]; asr is sign-filling.
- ld/st: aluResult = A+B.
- call: aluResult = pc+4.
- Unlisted opcodes behave as nop.
- cmp: flagE <= (A==B); flagGT <= ($signed(A) > $signed(B)), both updated at the accept edge. cmp is the only writer of the flags. A beq/bgt accepted the cycle after a cmp sees the new flags.
- Branches: isBranchTaken = b | call | ret | (beq & flagE) | (bgt & flagGT). branchPC = A for ret, branchTarget otherwise; 0 when not taken.
- div/mod FSM, IDLE -> DIV -> DONE -> IDLE:
  - At accept: latch |A|, |B|, result signs; in_ready drops.
  - DIV runs DIV_CYCLES restoring iterations.
  - DONE applies signs, registers aluResult, pulses out_valid, returns to IDLE.
  - Total: out_valid 34 cycles after the accept edge; in_ready low for 33 cycles.
  - Signed, truncate toward zero; remainder takes the dividend's sign.
- div/mod boundaries:
  - B==0: quotient 0xFFFFFFFF, remainder = A. Bypasses DIV; latency 1.
  - A=0x80000000, B=-1: quotient 0x80000000, remainder 0. Must be correct via the normal path.
- flush:
  - In IDLE: suppresses the accept that cycle.
  - In DIV/DONE: aborts, returns to IDLE next cycle, no out_valid, flags unchanged.
  - flush has priority over completion.
- stop: retires with out_valid, then halted=1 and in_ready=0 until reset.
- Reset mid-division: immediate IDLE, no output pulse.

Decomposition:
- Package ex_pkg holds the opcode localparams (OP_ADD..OP_RET, OP_STOP) and the FSM state enum (IDLE, DIV, DONE).
- Sub-module serial_divider: unsigned restoring divider with ports start, dividend, divisor, abort, done, quotient, remainder.
- Sign handling and the B==0 bypass live in ex_unit.

Test Plan:
- Arithmetic: add A=0x7FFFFFFF, B=1 -> aluResult 0x80000000, out_valid 1 cycle later. mul 0x10000×0x10000 -> 0. asr 0x80000000 by 4 -> 0xF8000000.
- Compare/branch: cmp A=5,B=5, then beq with branchTarget=0x40 -> flagE=1, isBranchTaken=1, branchPC=0x40. cmp A=-1,B=1, then bgt -> not taken, flagGT=0.
- Division: div A=-7,B=2 -> in_ready low 33 cycles, aluResult 0xFFFFFFFD (-3) at cycle 34. mod A=-7,B=2 -> 0xFFFFFFFF (-1). Division stress: back-to-back divides must not overlap.
- Division edge cases: div A=0x80000000,B=-1 -> 0x80000000; mod -> 0. div A=9,B=0 -> 0xFFFFFFFF, latency 1; mod -> 9.
- Flush/reset abort: flush at cycle 10 of a div -> no out_valid, in_ready=1 at cycle 11, a following add completes normally. rst_n low mid-div -> all outputs 0 asynchronously.
- Control flow: ret with A=0x100 -> taken, branchPC 0x100. call at pc=0x20 -> aluResult 0x24. stop -> halted=1, in_ready stays 0 under continued in_valid.
